// File: rtl/ha_result_packer_if.sv
// ----------------------------------------------------------------------------
// ha_result_packer_if
//   Bundles the half-adder result input stream and the packed-word output
//   stream of ha_result_packer.
//
//   Parameters
//     WIDTH   bits per packed word (>= 2)
//     CNT_W   derived width of the bit counter / carry count
//
//   Signals
//     in_valid, in_sum, in_carry   source -> packer   result bit pair
//     in_ready                     packer -> source   pair accepted this cycle
//     flush                        source -> packer   emit partial word
//     out_valid                    packer -> sink     packed word available
//     out_ready                    sink   -> packer   word accepted
//     out_sum, out_carry           packer -> sink     packed bits, LSB first
//     out_len                      packer -> sink     valid bits in the word
//     out_ccount                   packer -> sink     ones in out_carry
//     out_parity                   packer -> sink     XOR of valid sum bits
//                                                     (HA_PACK_PARITY_EN only)
//
//   Modports
//     master  source/sink side (drives inputs, consumes outputs)
//     slave   packer side
//
//   Build option: HA_PACK_PARITY_EN adds out_parity.
// ----------------------------------------------------------------------------
interface ha_result_packer_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_sum;
    logic             in_carry;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [WIDTH-1:0] out_carry;
    logic [CNT_W-1:0] out_len;
    logic [CNT_W-1:0] out_ccount;
`ifdef HA_PACK_PARITY_EN
    logic             out_parity;
`endif

    modport master (
`ifdef HA_PACK_PARITY_EN
        input  out_parity,
`endif
        output in_valid,
        output in_sum,
        output in_carry,
        input  in_ready,
        output flush,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_carry,
        input  out_len,
        input  out_ccount
    );

    modport slave (
`ifdef HA_PACK_PARITY_EN
        output out_parity,
`endif
        input  in_valid,
        input  in_sum,
        input  in_carry,
        output in_ready,
        input  flush,
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_carry,
        output out_len,
        output out_ccount
    );

endinterface

// File: rtl/ha_result_packer.sv
// ----------------------------------------------------------------------------
// ha_result_packer
//   Collects the per-cycle (sum, carry) bit pairs of the registered half adder
//   into WIDTH-bit words, LSB first, and offers each word over a valid/ready
//   handshake with a single-entry output slot. A flush pulse emits a partial
//   word; a flush that arrives while the slot is occupied is remembered until
//   the slot frees up.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous reset, active high
//     bus   ha_result_packer_if.slave (input pair stream, flush, output word)
//
//   Build option: define HA_PACK_PARITY_EN to add bus.out_parity, the XOR of
//   the valid sum bits, registered with the word. Without it there is no
//   parity logic at all.
//
//   State | meaning
//   ------+------------------------------------------------------------------
//   FILL  | collecting bits; next pair is accepted unconditionally, or the
//         | output slot is empty
//   STALL | only the completing bit is missing and the slot still holds a
//         | word; that bit waits for out_ready
// ----------------------------------------------------------------------------
module ha_result_packer #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    ha_result_packer_if.slave     bus
);

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] fill_sum;
    logic [WIDTH-1:0] fill_carry;
    logic             flush_pend;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [WIDTH-1:0] out_carry_q;
    logic [CNT_W-1:0] out_len_q;
    logic [CNT_W-1:0] out_ccount_q;

    logic             out_free;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] fill_sum_nxt;
    logic [WIDTH-1:0] fill_carry_nxt;
    logic [CNT_W-1:0] cnt_acc;
    logic             complete;
    logic             flush_req;
    logic             load_part;
    logic             valid_hold;
    logic [CNT_W-1:0] ccount_nxt;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        out_free       = !out_valid_q || bus.out_ready;
        // STALL already encodes "last bit pending and slot occupied", so the
        // only thing that can release it this cycle is the consumer.
        in_ready       = (state == FILL) || bus.out_ready;
        accept         = bus.in_valid && in_ready;

        fill_sum_nxt   = fill_sum;
        fill_carry_nxt = fill_carry;
        for (int i = 0; i < WIDTH; i++) begin
            if (accept && (cnt == CNT_W'(i))) begin
                fill_sum_nxt[i]   = bus.in_sum;
                fill_carry_nxt[i] = bus.in_carry;
            end
        end

        cnt_acc    = cnt + {{(CNT_W-1){1'b0}}, accept};
        complete   = accept && (cnt == LAST_IDX);
        flush_req  = bus.flush || flush_pend;
        // A completing bit always wins over a flush: the word is full anyway.
        load_part  = !complete && flush_req && out_free && (cnt_acc != '0);
        valid_hold = out_valid_q && !bus.out_ready;
        ccount_nxt = popcount(fill_carry_nxt);
    end

`ifdef HA_PACK_PARITY_EN
    logic out_parity_q;
    // Unused upper fill bits are always zero, so the full-vector XOR equals
    // the XOR of the first out_len bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity_q <= 1'b0;
        end else if (complete || load_part) begin
            out_parity_q <= ^fill_sum_nxt;
        end
    end
    assign bus.out_parity = out_parity_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            cnt          <= '0;
            fill_sum     <= '0;
            fill_carry   <= '0;
            flush_pend   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_carry_q  <= '0;
            out_len_q    <= '0;
            out_ccount_q <= '0;
        end else if (complete || load_part) begin
            out_valid_q  <= 1'b1;
            out_sum_q    <= fill_sum_nxt;
            out_carry_q  <= fill_carry_nxt;
            out_len_q    <= complete ? FULL_LEN : cnt_acc;
            out_ccount_q <= ccount_nxt;
            cnt          <= '0;
            fill_sum     <= '0;
            fill_carry   <= '0;
            flush_pend   <= 1'b0;
            state        <= FILL;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            cnt        <= cnt_acc;
            fill_sum   <= fill_sum_nxt;
            fill_carry <= fill_carry_nxt;
            // Any flush request that did not load here found the slot busy
            // with bits already captured; an empty-word flush is dropped.
            flush_pend <= flush_req && (cnt_acc != '0);
            state      <= ((cnt_acc == LAST_IDX) && valid_hold) ? STALL : FILL;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.out_carry  = out_carry_q;
    assign bus.out_len    = out_len_q;
    assign bus.out_ccount = out_ccount_q;

    // Word-level invariants.
    a_len_nonzero : assert property (@(posedge clk) disable iff (rst)
        out_valid_q |-> (out_len_q != '0));
    a_ccount_le_len : assert property (@(posedge clk) disable iff (rst)
        out_ccount_q <= out_len_q);
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_sum_q) && $stable(out_carry_q) &&
             $stable(out_len_q) && $stable(out_ccount_q)));

endmodule
